range_window_sequencer: RTL
===========================

// Module: range_window_sequencer
// PURPOSE
//  Frames a raw sample stream into fixed-length windows and drives the go/finish/data
//  interface of the min/max range unit (result = high - low), one window at a time.
//  Captures the unit's result after each window and returns it on a valid/ready port.
//  Sits between the sample source and the range datapath; the range unit shares clock/reset.
// PARAMETERS
//  DATA_W       10   sample and result width (matches range unit data path)
//  CNT_W        8    window-length / sample-counter width
//  TIMEOUT_CYC  255  idle-sample limit in ACTIVE (used only with RANGE_SEQ_TIMEOUT_EN)
// PORTS
//  clock        in   1       single clock, rising edge
//  reset        in   1       asynchronous, active-high; clears all state
//  start        in   1       begin a window (accepted only in IDLE)
//  win_len      in   CNT_W   samples per window, latched on accepted start
//  abort        in   1       cancel current window; no result produced
//  in_valid     in   1       sample_data valid
//  sample_data  in   DATA_W  input sample
//  in_ready     out  1       sample accepted when in_valid && in_ready
//  rf_go        out  1       to range unit go (registered)
//  rf_finish    out  1       to range unit finish (registered)
//  rf_data      out  DATA_W  to range unit data_in (registered, holds last sample)
//  rf_result    in   DATA_W  range unit output (high - low)
//  out_valid    out  1       result available
//  out_ready    in   1       consumer accepts result
//  out_range    out  DATA_W  captured result, stable while out_valid
//  busy         out  1       state != IDLE
//  abort_pulse  out  1       1-cycle pulse when an abort/timeout terminates a window
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (rf_data=0, out_range=0); counters 0.
//  FSM: IDLE -> ACTIVE -> FINISH -> CAPTURE -> RESULT -> IDLE.
//  IDLE: in_ready=0. start=1 -> latch L = (win_len<2 ? 2 : win_len); cnt=0; -> ACTIVE.
//  ACTIVE: in_ready = !abort. Each accepted sample: rf_data<=sample_data, cnt++.
//   First accept (cnt==0): rf_go=1 for exactly the following cycle.
//   Accept making cnt==L: -> FINISH; rf_finish=1 next cycle, rf_data = last sample.
//   No valid sample: rf_data holds (repeat does not disturb min/max).
//  FINISH (1 cyc): rf_finish=1. -> CAPTURE.
//  CAPTURE (1 cyc): out_range<=rf_result. -> RESULT.
//   Latency: last accept at cycle t -> rf_finish at t+1 -> out_valid at t+3.
//  RESULT: out_valid=1, out_range stable; out_valid&&out_ready -> IDLE (out_valid 0 next cycle).
//  rf_go and rf_finish never high in the same cycle (L>=2 guarantees this).
//  Abort (ACTIVE only; ignored in other states): blocks acceptance that cycle.
//   cnt==0: -> IDLE, abort_pulse=1, no rf_finish.
//   cnt>=1: rf_finish=1 next cycle to close unit, abort_pulse=1, -> IDLE; no out_valid.
//  start outside IDLE ignored; win_len changes after latch ignored.
//  cnt width CNT_W, no wrap: L <= 2^CNT_W-1 so cnt never overflows.
//  Reset mid-window: immediate return to reset values; no result emitted.
// CONFIGURATION
//  RANGE_SEQ_TIMEOUT_EN defined: in ACTIVE, a cycle counter clears on each accept and
//   increments otherwise; reaching TIMEOUT_CYC is treated exactly as abort (same cnt rules).
//  RANGE_SEQ_TIMEOUT_EN undefined: no timeout; ACTIVE waits for samples indefinitely.
// TESTING
//  win_len=4, samples 100,50,300,200 back-to-back -> one rf_go, rf_finish 1 cyc after
//   4th accept, out_valid 3 cyc after 4th accept, out_range=250.
//  win_len=0, samples 7,7 -> window treated as 2, out_range=0; win_len=1 same.
//  win_len=3, in_valid gaps of 4 cyc, samples 5,900,12 -> rf_data holds between, out_range=895.
//  out_ready low 6 cyc in RESULT -> out_valid/out_range held, start ignored, in_ready=0.
//  win_len=4, abort after 2 accepts -> rf_finish next cyc, abort_pulse=1, no out_valid, IDLE;
//   abort before first accept -> no rf_go/rf_finish.
//  reset asserted mid-ACTIVE -> all outputs 0 same cycle; next start runs a clean window.
//  (TIMEOUT_EN, TIMEOUT_CYC=8) 1 accept then silence -> abort_pulse 8 cyc later, rf_finish.

Source files
------------

// File: rtl/range_window_sequencer.sv
// rtl/range_window_sequencer.sv - frames samples into windows for the min/max range unit
// Optional idle-sample timeout in ACTIVE is enabled by defining RANGE_SEQ_TIMEOUT_EN.
module range_window_sequencer #(
   parameter int DATA_W      = 10,
   parameter int CNT_W       = 8,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [CNT_W-1:0]  win_len,
   input  logic              abort,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] sample_data,
   output logic              in_ready,
   output logic              rf_go,
   output logic              rf_finish,
   output logic [DATA_W-1:0] rf_data,
   input  logic [DATA_W-1:0] rf_result,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_range,
   output logic              busy,
   output logic              abort_pulse
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACTIVE,
      S_FINISH,
      S_CAPTURE,
      S_RESULT
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  len_q, len_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  cnt_inc;
   logic              rf_go_q, rf_go_d;
   logic              rf_finish_q, rf_finish_d;
   logic [DATA_W-1:0] rf_data_q, rf_data_d;
   logic [DATA_W-1:0] out_range_q, out_range_d;
   logic              abort_pulse_q, abort_pulse_d;
   logic              timeout_hit;
   logic              stop_win;
   logic              accept;

`ifdef RANGE_SEQ_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

   logic [TO_W-1:0] idle_q, idle_d;

   assign timeout_hit = (state_q == S_ACTIVE) && (idle_q == TO_W'(TIMEOUT_CYC));

   always_comb begin
      idle_d = '0;
      if (state_q == S_ACTIVE && !accept) begin
         idle_d = idle_q + TO_W'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         idle_q <= '0;
      end else begin
         idle_q <= idle_d;
      end
   end
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = ^TIMEOUT_CYC;
   assign timeout_hit        = 1'b0;
`endif

   // A timeout is handled exactly like an abort, including blocking acceptance.
   assign stop_win = (state_q == S_ACTIVE) && (abort || timeout_hit);
   assign in_ready = (state_q == S_ACTIVE) && !abort && !timeout_hit;
   assign accept   = in_ready && in_valid;
   assign cnt_inc  = cnt_q + CNT_W'(1);

   always_comb begin
      state_d       = state_q;
      len_d         = len_q;
      cnt_d         = cnt_q;
      rf_go_d       = 1'b0;
      rf_finish_d   = 1'b0;
      rf_data_d     = rf_data_q;
      out_range_d   = out_range_q;
      abort_pulse_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               len_d   = (win_len < CNT_W'(2)) ? CNT_W'(2) : win_len;
               cnt_d   = '0;
               state_d = S_ACTIVE;
            end
         end
         S_ACTIVE: begin
            if (stop_win) begin
               // Close the range unit only if it has been opened by a go.
               abort_pulse_d = 1'b1;
               rf_finish_d   = (cnt_q != '0);
               cnt_d         = '0;
               state_d       = S_IDLE;
            end else if (accept) begin
               rf_data_d = sample_data;
               cnt_d     = cnt_inc;
               rf_go_d   = (cnt_q == '0);
               if (cnt_inc == len_q) begin
                  rf_finish_d = 1'b1;
                  state_d     = S_FINISH;
               end
            end
         end
         S_FINISH: begin
            state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            out_range_d = rf_result;
            state_d     = S_RESULT;
         end
         S_RESULT: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         len_q         <= '0;
         cnt_q         <= '0;
         rf_go_q       <= 1'b0;
         rf_finish_q   <= 1'b0;
         rf_data_q     <= '0;
         out_range_q   <= '0;
         abort_pulse_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         len_q         <= len_d;
         cnt_q         <= cnt_d;
         rf_go_q       <= rf_go_d;
         rf_finish_q   <= rf_finish_d;
         rf_data_q     <= rf_data_d;
         out_range_q   <= out_range_d;
         abort_pulse_q <= abort_pulse_d;
      end
   end

   assign rf_go       = rf_go_q;
   assign rf_finish   = rf_finish_q;
   assign rf_data     = rf_data_q;
   assign out_range   = out_range_q;
   assign abort_pulse = abort_pulse_q;
   assign out_valid   = (state_q == S_RESULT);
   assign busy        = (state_q != S_IDLE);

endmodule
